mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares the 4:1 Multiplexer between four requesters (A,B,C,D = Req[0..3]).

---
 rtl/mux_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter sharing a 4:1 multiplexer between four requesters.
// Registered one-hot grant and mux select; a hold limit bounds each grant under contention.
module mux_rr_arbiter #(
    parameter int HOLD_MAX = 4,
    parameter int CW       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Req,
    output logic [3:0] Gnt,
    output logic [1:0] Sel,
    output logic       Valid
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [CW-1:0] HOLD = CW'(HOLD_MAX);

    state_t        state, state_nxt;
    logic [1:0]    ptr, ptr_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    gnt_nxt;
    logic [1:0]    sel_nxt;
    logic          valid_nxt;
    logic [3:0]    others;
    logic [1:0]    owner;

    // First set bit of r, scanning start, start+1, ... mod 4. Callers guarantee r != 0.
    function automatic logic [1:0] first_from(input logic [3:0] r, input logic [1:0] start);
        logic [1:0] idx;
        logic       found;
        first_from = start;
        found      = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && r[idx]) begin
                first_from = idx;
                found      = 1'b1;
            end
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        return 4'b0001 << i;
    endfunction

    // Sel doubles as the current owner index; it keeps its value across IDLE.
    assign others = Req & ~onehot(Sel);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = Gnt;
        sel_nxt   = Sel;
        valid_nxt = Valid;
        owner     = Sel;
        case (state)
            IDLE: begin
                if (|Req) begin
                    owner     = first_from(Req, ptr);
                    state_nxt = GRANT;
                    gnt_nxt   = onehot(owner);
                    sel_nxt   = owner;
                    valid_nxt = 1'b1;
                    cnt_nxt   = CW'(1);
                end
            end
            GRANT: begin
                if (Req[Sel] && (cnt < HOLD || others == 4'b0000)) begin
                    if (cnt < HOLD) cnt_nxt = cnt + 1'b1;
                end else if (others != 4'b0000) begin
                    // Timeout and release both hand over to the next requester after the owner.
                    owner   = first_from(others, Sel + 2'd1);
                    ptr_nxt = Sel + 2'd1;
                    gnt_nxt = onehot(owner);
                    sel_nxt = owner;
                    cnt_nxt = CW'(1);
                end else begin
                    state_nxt = IDLE;
                    ptr_nxt   = Sel + 2'd1;
                    gnt_nxt   = 4'b0000;
                    valid_nxt = 1'b0;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd0;
            cnt   <= '0;
            Gnt   <= 4'b0000;
            Sel   <= 2'd0;
            Valid <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            Gnt   <= gnt_nxt;
            Sel   <= sel_nxt;
            Valid <= valid_nxt;
        end
    end

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(Gnt));
    a_valid_gnt   : assert property (@(posedge clk) disable iff (rst) Valid == (|Gnt));
    a_sel_match   : assert property (@(posedge clk) disable iff (rst) Valid |-> Gnt[Sel]);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: reset, rotation, hold saturation, release, idle return,
// and a HOLD_MAX=1 instance driving a modelled 4:1 mux.
module tb_mux_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req, req1;
    logic [3:0] gnt, gnt1;
    logic [1:0] sel, sel1;
    logic       valid, valid1;
    int         n_cmp = 0;
    int         n_bad = 0;

    localparam logic [7:0] DA = 8'hA0, DB = 8'hB1, DC = 8'hC2, DD = 8'hD3;
    logic [7:0] y1;

    mux_rr_arbiter #(.HOLD_MAX(4), .CW(3)) u_dut (
        .clk(clk), .rst(rst), .Req(req), .Gnt(gnt), .Sel(sel), .Valid(valid)
    );

    mux_rr_arbiter #(.HOLD_MAX(1), .CW(3)) u_dut1 (
        .clk(clk), .rst(rst), .Req(req1), .Gnt(gnt1), .Sel(sel1), .Valid(valid1)
    );

    // Downstream 4:1 multiplexer driven by the arbiter select.
    always_comb begin
        case (sel1)
            2'd0:    y1 = DA;
            2'd1:    y1 = DB;
            2'd2:    y1 = DC;
            default: y1 = DD;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int o;
        rst  = 1'b1;
        req  = 4'b0000;
        req1 = 4'b0000;
        #12;
        check("rst_gnt", gnt, 4'b0000);
        check("rst_sel", sel, 2'd0);
        check("rst_valid", valid, 1'b0);
        check("rst_ptr", u_dut.ptr, 2'd0);
        check("rst_cnt", u_dut.cnt, 3'd0);
        rst = 1'b0;

        // Async reset while C owns the mux.
        req = 4'b0100;
        tick();
        check("t1_gnt_c", gnt, 4'b0100);
        check("t1_sel_c", sel, 2'd2);
        check("t1_valid_c", valid, 1'b1);
        #3 rst = 1'b1;
        #1;
        check("t1_async_gnt", gnt, 4'b0000);
        check("t1_async_sel", sel, 2'd0);
        check("t1_async_valid", valid, 1'b0);
        check("t1_async_ptr", u_dut.ptr, 2'd0);
        #2;
        rst = 1'b0;
        req = 4'b0001;
        tick();
        check("t1_after_gnt", gnt, 4'b0001);
        check("t1_after_sel", sel, 2'd0);

        // Full contention from reset: four cycles per owner, A..D then A.
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 17; k++) begin
            tick();
            o = (k / 4) % 4;
            check("t2_gnt", gnt, 32'd1 << o);
            check("t2_sel", sel, o);
            check("t2_valid", valid, 1'b1);
            check("t2_cnt", u_dut.cnt, (k % 4) + 1);
        end

        // Lone requester C: no rotation, counter saturates.
        req = 4'b0100;
        for (int i = 1; i <= 10; i++) begin
            tick();
            check("t3_gnt", gnt, 4'b0100);
            check("t3_cnt", u_dut.cnt, (i < 4) ? i : 4);
        end
        check("t3_ptr", u_dut.ptr, 2'd1);

        // Steer to owner B with Ptr=1, then switch Req to D|A.
        req = 4'b0001;
        tick();
        check("t4_gnt_a", gnt, 4'b0001);
        check("t4_ptr_a", u_dut.ptr, 2'd3);
        req = 4'b0010;
        tick();
        check("t4_gnt_b", gnt, 4'b0010);
        check("t4_ptr_b", u_dut.ptr, 2'd1);
        req = 4'b1001;
        tick();
        check("t4_gnt_d", gnt, 4'b1000);
        check("t4_sel_d", sel, 2'd3);

        // D releases with nothing pending: idle, Sel held, Ptr wraps to 0.
        req = 4'b0000;
        tick();
        check("t5_gnt", gnt, 4'b0000);
        check("t5_valid", valid, 1'b0);
        check("t5_sel", sel, 2'd3);
        check("t5_ptr", u_dut.ptr, 2'd0);
        check("t5_cnt", u_dut.cnt, 3'd0);
        tick();
        check("t5_idle_gnt", gnt, 4'b0000);
        check("t5_idle_sel", sel, 2'd3);
        req = 4'b0011;
        tick();
        check("t5_new_gnt", gnt, 4'b0001);
        check("t5_new_sel", sel, 2'd0);
        req = 4'b0000;

        // HOLD_MAX=1: A and C alternate every cycle, and so does the mux output.
        req1 = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t6_gnt", gnt1, (k % 2 == 0) ? 4'b0001 : 4'b0100);
            check("t6_sel", sel1, (k % 2 == 0) ? 2'd0 : 2'd2);
            check("t6_valid", valid1, 1'b1);
            check("t6_y", y1, (k % 2 == 0) ? DA : DC);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
